cdp_lut_access_arb: RTL

CDP_LUT_ACCESS_ARB -- requirements
Module: cdp_lut_access_arb

---
 rtl/cdp_lut_pkg.sv | 18 +
 rtl/cdp_lut_rsp_fifo.sv | 46 ++++
 rtl/cdp_lut_access_arb.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cdp_lut_pkg.sv
// Shared LUT access types and constants for the CDP lookup-table arbiter and its sub-blocks.
package cdp_lut_pkg;

  localparam int LUT_DW     = 16;
  localparam int LUT_AW     = 9;
  localparam int RAM_RD_LAT = 1;

  typedef enum logic {
    TBL_LE = 1'b0,
    TBL_LO = 1'b1
  } lut_tbl_e;

  typedef enum logic {
    OWN_DP  = 1'b0,
    OWN_CFG = 1'b1
  } rd_owner_e;

endpackage

// File: rtl/cdp_lut_rsp_fifo.sv
// 2-entry in-order response FIFO; head is registered, so a push is visible one cycle later.
// No overflow protection: the upstream credit count guarantees a push never hits a full FIFO.
module cdp_lut_rsp_fifo
  import cdp_lut_pkg::*;
#(
  parameter int DW = LUT_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic          vld,
  output logic [DW-1:0] head,
  output logic [1:0]    cnt
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign vld  = (cnt_q != 2'd0);
  assign head = mem[rd_ptr];
  assign cnt  = cnt_q;

endmodule

// File: rtl/cdp_lut_access_arb.sv
// Arbitrates datapath lookups and register-side LUT accesses onto one single-port RAM; dp wins by
// default, cfg is forced after CFG_STARVE_MAX denials. dp: 2-cycle latency, credit back-pressure; cfg: 1-cycle read, no back-pressure.
module cdp_lut_access_arb
  import cdp_lut_pkg::*;
#(
  parameter int CFG_STARVE_MAX = 16,
  parameter int DW             = LUT_DW
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              dp_req_pvld,
  output logic              dp_req_prdy,
  input  logic              dp_req_tbl,
  input  logic [LUT_AW-1:0] dp_req_addr,
  output logic              dp_rsp_pvld,
  input  logic              dp_rsp_prdy,
  output logic [DW-1:0]     dp_rsp_data,
  input  logic              cfg_req_pvld,
  output logic              cfg_req_prdy,
  input  logic              cfg_req_wr,
  input  logic              cfg_req_tbl,
  input  logic [LUT_AW-1:0] cfg_req_addr,
  input  logic [DW-1:0]     cfg_req_wdat,
  output logic              cfg_rsp_pvld,
  output logic [DW-1:0]     cfg_rsp_data,
  output logic              ram_re,
  output logic              ram_we,
  output logic              ram_tbl,
  output logic [LUT_AW-1:0] ram_addr,
  output logic [DW-1:0]     ram_wdat,
  input  logic [DW-1:0]     ram_rdat
);

  localparam int SW = $clog2(CFG_STARVE_MAX + 1);

  logic [SW-1:0]     starve_cnt;
  logic              tag_vld;
  rd_owner_e         tag_own;
  logic              last_tbl;
  logic [LUT_AW-1:0] last_addr;
  logic [DW-1:0]     last_wdat;

  logic [1:0] fifo_cnt;
  logic [1:0] credit;
  logic       fifo_push;
  logic       fifo_pop;
  logic       cfg_force;
  logic       dp_room;
  logic       dp_acc;
  logic       cfg_acc;

  assign fifo_pop  = dp_rsp_pvld & dp_rsp_prdy;
  assign fifo_push = tag_vld & (tag_own == OWN_DP);
  assign credit    = fifo_cnt + {1'b0, fifo_push};
  assign cfg_force = cfg_req_pvld & (starve_cnt == SW'(CFG_STARVE_MAX));
  assign dp_room   = (credit < 2'd2) | ((credit == 2'd2) & fifo_pop);

  // Ready is gated by reset directly so acceptance is possible on the very first edge after release.
  assign dp_req_prdy  = nvdla_core_rstn & ~cfg_force & dp_room;
  assign dp_acc       = dp_req_pvld & dp_req_prdy;
  assign cfg_req_prdy = nvdla_core_rstn & ~dp_acc;
  assign cfg_acc      = cfg_req_pvld & cfg_req_prdy;

  assign ram_re = dp_acc | (cfg_acc & ~cfg_req_wr);
  assign ram_we = cfg_acc & cfg_req_wr;

  always_comb begin
    ram_tbl  = last_tbl;
    ram_addr = last_addr;
    ram_wdat = last_wdat;
    if (dp_acc) begin
      ram_tbl  = dp_req_tbl;
      ram_addr = dp_req_addr;
    end else if (cfg_acc) begin
      ram_tbl  = cfg_req_tbl;
      ram_addr = cfg_req_addr;
      ram_wdat = cfg_req_wdat;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      starve_cnt <= '0;
      tag_vld    <= 1'b0;
      tag_own    <= OWN_DP;
      last_tbl   <= 1'b0;
      last_addr  <= '0;
      last_wdat  <= '0;
    end else begin
      if (!cfg_req_pvld || cfg_acc) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SW'(CFG_STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      tag_vld <= ram_re;
      tag_own <= dp_acc ? OWN_DP : OWN_CFG;
      if (ram_re || ram_we) begin
        last_tbl  <= ram_tbl;
        last_addr <= ram_addr;
        last_wdat <= ram_wdat;
      end
    end
  end

  // cfg read data bypasses the FIFO: the register side never stalls.
  assign cfg_rsp_pvld = tag_vld & (tag_own == OWN_CFG);
  assign cfg_rsp_data = cfg_rsp_pvld ? ram_rdat : '0;

  cdp_lut_rsp_fifo #(.DW(DW)) u_rsp_fifo (
    .clk      (nvdla_core_clk),
    .rst_n    (nvdla_core_rstn),
    .push     (fifo_push),
    .push_dat (ram_rdat),
    .pop      (fifo_pop),
    .vld      (dp_rsp_pvld),
    .head     (dp_rsp_data),
    .cnt      (fifo_cnt)
  );

endmodule
